// File: rtl/register_display_if.sv
// Bus between the CPU register file and the seven-segment register display.
interface register_display_if #(
  parameter int REGISTER_WIDTH = 8,
  parameter int DIGITS         = 3
);
  logic [REGISTER_WIDTH-1:0] register1Value;
  logic [6:0]                segments;
  logic [DIGITS-1:0]         anodes;
  logic                      busy;
  logic                      updated;
  logic [4*DIGITS-1:0]       bcd;

  modport master (
    output register1Value,
    input  segments, anodes, busy, updated, bcd
  );

  modport slave (
    input  register1Value,
    output segments, anodes, busy, updated, bcd
  );
endinterface

// File: rtl/register_display.sv
// Shows R1 in decimal on a multiplexed 7-segment display: double-dabble
// conversion on every value change, then a free-running digit scan.
module register_display #(
  parameter int REGISTER_WIDTH = 8,
  parameter int DIGITS         = 3,
  parameter int REFRESH_DIV    = 16,
  parameter int BLANK_ZEROS    = 1
) (
  input  logic              clock,
  input  logic              isReset,
  register_display_if.slave bus
);
  localparam int AW  = 4 * DIGITS;
  localparam int BW  = $clog2(REGISTER_WIDTH + 1);
  localparam int CW  = $clog2(REFRESH_DIV);
  localparam int DSW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LATCH
  } state_t;

  state_t                    r_state;
  logic [REGISTER_WIDTH-1:0] r_last_value;
  logic [REGISTER_WIDTH-1:0] r_sr;
  logic [AW-1:0]             r_acc;
  logic [BW-1:0]             r_bitcnt;
  logic [AW-1:0]             r_bcd;
  logic                      r_busy;
  logic                      r_updated;
  logic [CW-1:0]             r_refresh;
  logic [DSW-1:0]            r_dsel;

  logic [AW-1:0]                w_adj;
  logic [AW+REGISTER_WIDTH-1:0] w_shift;
  logic [3:0]                   w_digit;
  logic                         w_blank;
  logic [DIGITS-1:0]            w_anodes;
  logic [6:0]                   w_seg;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    w_adj = r_acc;
    for (int unsigned n = 0; n < DIGITS; n++) begin
      if (r_acc[4*n +: 4] >= 4'd5) begin
        w_adj[4*n +: 4] = r_acc[4*n +: 4] + 4'd3;
      end
    end
    w_shift = {w_adj, r_sr} << 1;
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      r_state      <= IDLE;
      r_last_value <= '0;
      r_sr         <= '0;
      r_acc        <= '0;
      r_bitcnt     <= '0;
      r_bcd        <= '0;
      r_busy       <= 1'b0;
      r_updated    <= 1'b0;
    end else begin
      r_updated <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.register1Value != r_last_value) begin
            r_sr         <= bus.register1Value;
            r_acc        <= '0;
            r_bitcnt     <= '0;
            r_last_value <= bus.register1Value;
            r_busy       <= 1'b1;
            r_state      <= CONVERT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        CONVERT: begin
          r_acc    <= w_shift[AW+REGISTER_WIDTH-1:REGISTER_WIDTH];
          r_sr     <= w_shift[REGISTER_WIDTH-1:0];
          r_bitcnt <= r_bitcnt + BW'(1);
          if (r_bitcnt == BW'(REGISTER_WIDTH - 1)) begin
            r_state <= LATCH;
          end
        end
        LATCH: begin
          // busy is held through this cycle; IDLE decides whether it drops.
          r_bcd     <= r_acc;
          r_updated <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      r_refresh <= '0;
      r_dsel    <= '0;
    end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_dsel    <= (r_dsel == DSW'(DIGITS - 1)) ? '0 : r_dsel + DSW'(1);
    end else begin
      r_refresh <= r_refresh + CW'(1);
    end
  end

  always_comb begin
    w_digit  = r_bcd[3:0];
    w_blank  = 1'b0;
    w_anodes = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_dsel == DSW'(k)) begin
        w_digit     = r_bcd[4*k +: 4];
        w_anodes[k] = 1'b0;
        w_blank     = (BLANK_ZEROS != 0) && (k != 0) && ((r_bcd >> (4*k)) == '0);
      end
    end
  end

  always_comb begin
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b1111111;
    endcase
    if (w_blank) begin
      w_seg = 7'b1111111;
    end
  end

  assign bus.segments = w_seg;
  assign bus.anodes   = w_anodes;
  assign bus.busy     = r_busy;
  assign bus.updated  = r_updated;
  assign bus.bcd      = r_bcd;
endmodule

// File: doc/register_display.md
REGISTER_DISPLAY -- requirements
Module: register_display

Interface
REQ-001 Parameter REGISTER_WIDTH, default 8: width of the displayed register value.
REQ-002 Parameter DIGITS, default 3: number of BCD digits shown (covers 0..255).
REQ-003 Parameter REFRESH_DIV, default 16: clock cycles each digit stays selected; legal range 2..65535.
REQ-004 Parameter BLANK_ZEROS, default 1: 1 blanks leading zero digits.
REQ-005 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 isReset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-007 register1Value  in  REGISTER_WIDTH  unsigned value from the CPU register file (R1).
REQ-008 segments  out  7  active-low segment drives, bit order {g,f,e,d,c,b,a}.
REQ-009 anodes  out  DIGITS  active-low one-hot digit enables; bit 0 is the least significant digit.
REQ-010 busy  out  1  high while a binary-to-BCD conversion is in progress.
REQ-011 updated  out  1  one-cycle pulse when new digits are latched.
REQ-012 bcd  out  4*DIGITS  latched BCD value currently displayed; digit 0 is in bits [3:0].

Function
REQ-013 The FSM SHALL have three states: IDLE, CONVERT and LATCH.
REQ-014 IDLE: when register1Value != lastValue, the block SHALL load the shift register with register1Value, clear the BCD accumulator and the bit count, set lastValue <= register1Value, and enter CONVERT; otherwise it SHALL stay in IDLE.
REQ-015 CONVERT, each cycle, in this order:
- add 3 to every accumulator nibble that is >= 5;
- shift {accumulator, shift register} left by 1;
- increment the bit count.
REQ-016 CONVERT SHALL enter LATCH on the cycle in which the bit count reaches REGISTER_WIDTH-1 (REGISTER_WIDTH conversion cycles in total).
REQ-017 LATCH: bcd <= accumulator, updated = 1 for this one cycle, then IDLE.
REQ-018 Latency: change sampled at edge N SHALL appear on bcd after edge N+REGISTER_WIDTH+1; busy SHALL be high from edge N through edge N+REGISTER_WIDTH+1.
REQ-019 Changes to register1Value while busy SHALL be ignored; on returning to IDLE, a still-differing value SHALL start a new conversion on the next edge.
REQ-020 The refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, digitSelect SHALL advance 0->1->...->DIGITS-1->0.
REQ-021 anodes[k] SHALL be 0 exactly when digitSelect == k, and 1 otherwise.
REQ-022 segments SHALL be the active-low pattern of bcd digit[digitSelect]; 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 With BLANK_ZEROS=1, a digit k>0 SHALL show 1111111 when it and every higher digit are zero; digit 0 SHALL never be blanked.
REQ-024 Nibble codes 10..15 SHALL never occur on bcd; if one does, segments SHALL show 1111111.
REQ-025 segments and anodes SHALL depend only on registered state; bcd, busy and updated SHALL be registered.

Reset
REQ-026 On isReset=1, the block SHALL set: state=IDLE, lastValue=0, bcd=0, refresh counter=0, digitSelect=0, busy=0, updated=0.
REQ-027 After reset, outputs SHALL be anodes={DIGITS-1{1},0}, segments=1000000, and no conversion SHALL be in progress.
REQ-028 isReset SHALL override any in-flight conversion on the same edge; the partial result SHALL be discarded.
REQ-029 If register1Value != 0 at reset release, a conversion SHALL start on the first edge with isReset=0.

Verification
REQ-030 Reset with register1Value=0 -> bcd=12'h000, anodes=110, segments=1000000, busy=0, and no updated pulse for 50 cycles.
REQ-031 register1Value=8'hFF -> busy high for 10 edges, one updated pulse, bcd=12'h255; digits display 5,5,2.
REQ-032 register1Value=8'd7, BLANK_ZEROS=1 -> bcd=12'h007; digit 0 shows 1111000; digits 1 and 2 show 1111111.
REQ-033 register1Value=100, then 200 two cycles later -> bcd=12'h100 with an updated pulse, then bcd=12'h200 with a second pulse; no other pulses.
REQ-034 isReset asserted 4 cycles into converting 8'd255 -> next edge: busy=0, bcd=12'h000; a new conversion starts after release, ending with bcd=12'h255.
REQ-035 REFRESH_DIV=4, register1Value=8'd123 -> anodes=110 for 4 cycles (segments 0110000), 101 for 4 (0100100), 011 for 4 (1111001), then repeats.
